// File: rtl/agc_scale_ctrl.sv
// agc_scale_ctrl: closed-loop shift control for the down-scaler, driven by the windowed mean |x| of its output.
// Manual mode drives the shift straight from scale_man_i; automatic mode steps it by one per window.
module agc_scale_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int SCALE_WIDTH = 5,
  parameter int WIN_LOG2    = 10,
  parameter int SETTLE_N    = 4,
  parameter int SCALE_MAX   = 31
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   agc_en_i,
  input  logic                   in_valid_i,
  input  logic [DATA_WIDTH-1:0]  in_i,
  input  logic [SCALE_WIDTH-1:0] scale_man_i,
  input  logic [DATA_WIDTH-1:0]  thr_hi_i,
  input  logic [DATA_WIDTH-1:0]  thr_lo_i,
  output logic [SCALE_WIDTH-1:0] scale_o,
  output logic [DATA_WIDTH-1:0]  level_o,
  output logic                   upd_o,
  output logic                   at_limit_o
);
  localparam int AW  = DATA_WIDTH + WIN_LOG2;
  localparam int SCW = SETTLE_N > 1 ? $clog2(SETTLE_N) : 1;
  localparam logic [SCALE_WIDTH-1:0] SMAX     = SCALE_WIDTH'(SCALE_MAX);
  localparam logic [SCW-1:0]         SET_LAST = SCW'(SETTLE_N - 1);

  typedef enum logic [1:0] {MANUAL, SETTLE, ACCUM, DECIDE} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [WIN_LOG2-1:0]    win_q, win_d;
  logic [SCW-1:0]         set_q, set_d;
  logic [SCALE_WIDTH-1:0] scale_q, scale_d;
  logic [DATA_WIDTH-1:0]  level_q, level_d;
  logic                   chg_q, chg_d;
  logic [DATA_WIDTH-1:0]  mag, mean;
  logic [AW-1:0]          acc_sum;
  logic                   up, dn;

  // Negating the most negative value yields 2**(DATA_WIDTH-1), which fits unsigned.
  assign mag     = in_i[DATA_WIDTH-1] ? -in_i : in_i;
  assign acc_sum = acc_q + AW'(mag);
  assign mean    = DATA_WIDTH'(acc_sum >> WIN_LOG2);
  assign up      = mean > thr_hi_i && scale_q < SMAX;
  assign dn      = !up && mean < thr_lo_i && scale_q != '0;

  // The window's decision is taken on its last sample so level, scale and upd appear together.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    win_d   = win_q;
    set_d   = set_q;
    scale_d = scale_q;
    level_d = level_q;
    chg_d   = chg_q;
    if (!agc_en_i && state_q != MANUAL) begin
      state_d = MANUAL;
      acc_d   = '0;
      win_d   = '0;
      set_d   = '0;
    end else begin
      case (state_q)
        MANUAL: begin
          scale_d = scale_man_i > SMAX ? SMAX : scale_man_i;
          acc_d   = '0;
          win_d   = '0;
          set_d   = '0;
          state_d = agc_en_i ? SETTLE : MANUAL;
        end
        SETTLE: if (in_valid_i) begin
          set_d = set_q + SCW'(1);
          if (set_q == SET_LAST) begin
            set_d   = '0;
            acc_d   = '0;
            win_d   = '0;
            state_d = ACCUM;
          end
        end
        ACCUM: if (in_valid_i) begin
          acc_d = acc_sum;
          win_d = win_q + WIN_LOG2'(1);
          if (&win_q) begin
            acc_d   = '0;
            level_d = mean;
            scale_d = up ? scale_q + SCALE_WIDTH'(1) : dn ? scale_q - SCALE_WIDTH'(1) : scale_q;
            chg_d   = up | dn;
            state_d = DECIDE;
          end
        end
        DECIDE: state_d = chg_q ? SETTLE : ACCUM;
        default: state_d = SETTLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= SETTLE;
      acc_q   <= '0;
      win_q   <= '0;
      set_q   <= '0;
      scale_q <= '0;
      level_q <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      win_q   <= win_d;
      set_q   <= set_d;
      scale_q <= scale_d;
      level_q <= level_d;
      chg_q   <= chg_d;
    end
  end

  assign scale_o    = scale_q;
  assign level_o    = level_q;
  assign upd_o      = state_q == DECIDE;
  assign at_limit_o = scale_q == '0 || scale_q == SMAX;
endmodule

// File: tb/tb_agc_scale_ctrl.sv
// tb_agc_scale_ctrl: randomized and directed stimulus against a window-level reference model of agc_scale_ctrl.
module tb_agc_scale_ctrl;
  localparam int DW = 8, SW = 5, WL = 4, SN = 4, SM = 7;

  logic          clk = 0, resetn = 0, agc_en = 0, in_valid = 0;
  logic [DW-1:0] in_d = '0, thr_hi = 8'd40, thr_lo = 8'd10;
  logic [SW-1:0] scale_man = '0;
  logic [SW-1:0] scale;
  logic [DW-1:0] level;
  logic          upd, at_limit;
  int            n_cmp = 0, n_bad = 0, tick_n = 0, n;
  bit            chk_on = 0;

  always #5 clk = ~clk;

  agc_scale_ctrl #(.DATA_WIDTH(DW), .SCALE_WIDTH(SW), .WIN_LOG2(WL), .SETTLE_N(SN), .SCALE_MAX(SM)) dut (
    .clk(clk), .resetn(resetn), .agc_en_i(agc_en), .in_valid_i(in_valid), .in_i(in_d),
    .scale_man_i(scale_man), .thr_hi_i(thr_hi), .thr_lo_i(thr_lo),
    .scale_o(scale), .level_o(level), .upd_o(upd), .at_limit_o(at_limit)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: samples to discard, a queue holding the current window, and a pending-decision flag.
  bit m_man, m_dec, m_chg;
  int m_settle, m_scale, m_level, m_sum, m_x;
  int win[$];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_man = 0; m_dec = 0; m_chg = 0; m_settle = SN; m_scale = 0; m_level = 0; win.delete();
    end else if (!agc_en) begin
      if (m_man) m_scale = scale_man > SM ? SM : scale_man;
      m_man = 1; m_dec = 0; win.delete();
    end else if (m_man) begin
      m_scale = scale_man > SM ? SM : scale_man;
      m_man = 0; m_settle = SN;
    end else if (m_dec) begin
      m_dec = 0; m_settle = m_chg ? SN : 0;
    end else if (in_valid) begin
      if (m_settle > 0) m_settle--;
      else begin
        m_x = $signed(in_d);
        win.push_back(m_x < 0 ? -m_x : m_x);
        if (win.size() == 2**WL) begin
          m_sum = 0;
          foreach (win[i]) m_sum += win[i];
          m_level = m_sum / (2**WL);
          m_chg = 1;
          if (m_level > thr_hi && m_scale < SM) m_scale++;
          else if (m_level < thr_lo && m_scale > 0) m_scale--;
          else m_chg = 0;
          m_dec = 1;
          win.delete();
        end
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("scale", scale, m_scale);
    chk("level", level, m_level);
    chk("upd", upd, m_dec);
    chk("at_limit", at_limit, m_scale == 0 || m_scale == SM);
  end

  // mode 0: constant val, 1: +/-val random sign, 2: random byte; duty 0 = random valid, else 1-of-duty
  task automatic tick(input int mode, input int val, input int duty);
    @(negedge clk);
    tick_n++;
    in_valid = duty == 0 ? $urandom_range(1) == 1 : tick_n % duty == 0;
    in_d = mode == 0 ? DW'(val) : mode == 1 ? ($urandom_range(1) == 1 ? DW'(val) : DW'(-val)) : DW'($urandom);
  endtask

  task automatic run(input int cnt, input int mode, input int val, input int duty);
    repeat (cnt) tick(mode, val, duty);
  endtask

  task automatic wait_upd(input int mode, input int val, input int duty, output int cnt);
    cnt = 0;
    do begin
      tick(mode, val, duty);
      cnt++;
    end while (!upd && cnt < 200);
    if (!upd) chk("upd_timeout", 0, 1);
  endtask

  task automatic go_manual(input int s);
    agc_en = 0;
    scale_man = SW'(s);
    run(3, 0, 0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_scale", scale, 0);
    chk("rst_level", level, 0);
    chk("rst_upd", upd, 0);
    chk("rst_at_limit", at_limit, 1);
    resetn = 1;
    chk_on = 1;
    go_manual(9);
    chk("t1_clamp", scale, 7);
    chk("t1_at_limit", at_limit, 1);
    scale_man = 3;
    tick(0, 0, 1);
    chk("t1_manual", scale, 3);

    thr_hi = 40; thr_lo = 10;
    agc_en = 1;
    wait_upd(1, 64, 1, n);
    chk("t2_upd_cycle", n, 21);
    chk("t2_level", level, 64);
    chk("t2_scale", scale, 4);
    wait_upd(1, 64, 1, n);
    chk("t2_period", n, 21);

    go_manual(3);
    agc_en = 1;
    wait_upd(0, 20, 1, n);
    wait_upd(0, 20, 1, n);
    chk("t3_period", n, 17);
    chk("t3_level", level, 20);
    chk("t3_scale", scale, 3);

    go_manual(3);
    agc_en = 1;
    run(200, 0, -128, 1);
    chk("t4_level", level, 128);
    chk("t4_scale", scale, 7);
    chk("t4_at_limit", at_limit, 1);

    go_manual(2);
    agc_en = 1;
    run(150, 0, 1, 1);
    chk("t5_level", level, 1);
    chk("t5_scale", scale, 0);
    chk("t5_at_limit", at_limit, 1);

    go_manual(3);
    agc_en = 1;
    run(200, 0, 20, 3);
    chk("t6_level", level, 20);
    chk("t6_scale", scale, 3);
    run(30, 0, 20, 3);
    #2 resetn = 0;
    #1;
    chk("t6_rst_scale", scale, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_upd", upd, 0);
    chk("t6_rst_at_limit", at_limit, 1);
    @(negedge clk);
    resetn = 1;
    run(200, 0, 20, 3);
    chk("t6_restart_level", level, 20);

    repeat (12) begin
      thr_hi = DW'($urandom_range(30, 100));
      thr_lo = DW'($urandom_range(20, 80));
      scale_man = SW'($urandom);
      agc_en = $urandom_range(4) != 0;
      run(200, $urandom_range(1, 2), $urandom_range(0, 128), $urandom_range(0, 2));
    end

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
